// File: rtl/regfile_check_sequencer_pkg.sv
// Shared types for the regfile check sequencer: script opcodes, FSM states
// and the field widths of a script entry {op, reg, value}.
package regfile_check_sequencer_pkg;

  localparam int OP_W  = 2;
  localparam int REG_W = 5;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 2'b00,
    OP_WAIT  = 2'b01,
    OP_CHECK = 2'b10,
    OP_END   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUN     = 2'b01,
    ST_DONE    = 2'b10,
    ST_TIMEOUT = 2'b11
  } state_e;

endpackage

// File: rtl/regfile_check_sequencer_shadow_regfile.sv
// Shadow copy of the CPU regfile built from snooped write-backs, with a
// combinational read port that forwards a same-cycle write. x0 reads as 0.
module shadow_regfile
  import regfile_check_sequencer_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_we,
  input  logic [REG_W-1:0] wb_addr,
  input  logic [XLEN-1:0]  wb_data,
  input  logic [REG_W-1:0] rd_addr,
  output logic [XLEN-1:0]  rd_data
);

  logic [XLEN-1:0] regs [NUM_REGS];

  // NOTE: this storage is reset entry by entry because a run must never compare
  // against values left over from before reset; the script RAM has no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_we && wb_addr != '0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  always_comb begin
    rd_data = regs[rd_addr];
    if (rd_addr == '0) begin
      rd_data = '0;
    end else if (wb_we && wb_addr == rd_addr) begin
      rd_data = wb_data;
    end
  end

endmodule

// File: rtl/regfile_check_sequencer.sv
// Script-driven WAIT/CHECK/END monitor over a shadowed regfile with a global
// run timeout. Define STOP_ON_FAIL_EN to end the run at the first CHECK mismatch.
module regfile_check_sequencer
  import regfile_check_sequencer_pkg::*;
#(
  parameter  int XLEN           = 32,
  parameter  int NUM_REGS       = 32,
  parameter  int DEPTH          = 16,
  parameter  int TIMEOUT_CYCLES = 1000,
  localparam int ADDR_W         = $clog2(DEPTH),
  localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1),
  localparam int ENTRY_W        = OP_W + REG_W + XLEN
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wb_we,
  input  logic [REG_W-1:0]   wb_addr,
  input  logic [XLEN-1:0]    wb_data,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_addr,
  input  logic [ENTRY_W-1:0] prog_data,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic               timed_out,
  output logic [ADDR_W:0]    fail_count,
  output logic [ADDR_W-1:0]  fail_idx
);

  logic [ENTRY_W-1:0] script [DEPTH];

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  pc_q;
  logic [CNT_W-1:0]   timer_q;
  logic [ADDR_W:0]    fail_count_q;
  logic [ADDR_W-1:0]  fail_idx_q;

  logic [ENTRY_W-1:0] entry;
  op_e                op;
  logic [REG_W-1:0]   ent_reg;
  logic [XLEN-1:0]    ent_val, cmp_val;
  logic               running, start_run, cmp_eq, last_entry, timeout_hit;
  logic               advance, check_fail, finish;

  assign running     = (state_q == ST_RUN);
  assign start_run   = start && !running;
  assign entry       = script[pc_q];
  assign op          = op_e'(entry[ENTRY_W-1 -: OP_W]);
  assign ent_reg     = entry[XLEN +: REG_W];
  assign ent_val     = entry[XLEN-1:0];
  assign cmp_eq      = (cmp_val == ent_val);
  assign last_entry  = (pc_q == ADDR_W'(DEPTH - 1));
  assign timeout_hit = (timer_q == CNT_W'(TIMEOUT_CYCLES - 1));

  shadow_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data),
    .rd_addr (ent_reg),
    .rd_data (cmp_val)
  );

  // The script is frozen while a run is in progress.
  always_ff @(posedge clk) begin
    if (prog_we && !running) script[prog_addr] <= prog_data;
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    advance    = 1'b0;
    check_fail = 1'b0;
    finish     = 1'b0;
    if (running) begin
      case (op)
        OP_WAIT:  advance = cmp_eq;
        OP_CHECK: begin
          advance    = 1'b1;
          check_fail = !cmp_eq;
        end
        default:  finish = 1'b1;  // OP_END, and OP_NOP treated as END
      endcase
      if (advance && last_entry) finish = 1'b1;
`ifdef STOP_ON_FAIL_EN
      if (check_fail) finish = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Completion in the timeout cycle takes priority over the timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (finish)           state_d = ST_DONE;
        else if (timeout_hit) state_d = ST_TIMEOUT;
      end
      default: if (start) state_d = ST_RUN;
    endcase
  end

  always_comb begin
    busy      = running;
    done      = (state_q == ST_DONE) || (state_q == ST_TIMEOUT);
    timed_out = (state_q == ST_TIMEOUT);
    pass      = (state_q == ST_DONE) && (fail_count_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      pc_q         <= '0;
      timer_q      <= '0;
      fail_count_q <= '0;
      fail_idx_q   <= '0;
    end else if (running) begin
      timer_q <= timer_q + CNT_W'(1);
      if (advance && !last_entry) pc_q <= pc_q + ADDR_W'(1);
      if (check_fail) begin
        if (fail_count_q != '1) fail_count_q <= fail_count_q + (ADDR_W+1)'(1);
        if (fail_count_q == '0) fail_idx_q   <= pc_q;
      end
    end
  end

  assign fail_count = fail_count_q;
  assign fail_idx   = fail_idx_q;

endmodule

// File: tb/tb_regfile_check_sequencer.sv
// Scoreboard bench: stimulus pushes the expected run result, a negedge monitor
// pops and compares it when done rises.
module tb_regfile_check_sequencer;
  import regfile_check_sequencer_pkg::*;

  localparam int XLEN = 32;
  localparam int EW   = 2 + 5 + XLEN;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            wb_we = 1'b0;
  logic [4:0]      wb_addr = '0;
  logic [XLEN-1:0] wb_data = '0;
  logic            prog_we = 1'b0;
  logic [3:0]      prog_addr = '0;
  logic [EW-1:0]   prog_data = '0;
  logic            start = 1'b0;
  logic            busy, done, pass, timed_out;
  logic [4:0]      fail_count;
  logic [3:0]      fail_idx;

  regfile_check_sequencer #(
    .XLEN(XLEN), .NUM_REGS(32), .DEPTH(16), .TIMEOUT_CYCLES(50)
  ) dut (
    .clk(clk), .rst(rst), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .start(start),
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
    .fail_count(fail_count), .fail_idx(fail_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string      name;
    logic       pass;
    logic       tmo;
    logic [4:0] fc;
    logic [3:0] fi;
    int         lat;   // cycles from start edge to done; -1 = not checked
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   start_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] ent(input op_e op, input int r, input logic [31:0] v);
    logic [4:0] ra;
    ra = r[4:0];
    return {op, ra, v};
  endfunction

  task automatic prog(input int a, input logic [EW-1:0] d);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = a[3:0]; prog_data = d;
    @(negedge clk);
    prog_we = 1'b0;
  endtask

  task automatic wb(input int a, input logic [31:0] d);
    @(negedge clk);
    wb_we = 1'b1; wb_addr = a[4:0]; wb_data = d;
    @(negedge clk);
    wb_we = 1'b0;
  endtask

  // Returns at the negedge right after the start edge.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic expect_run(input string n, input logic p, input logic t,
                            input int fc, input int fi, input int lat);
    exp_t e;
    e.name = n; e.pass = p; e.tmo = t; e.fc = fc[4:0]; e.fi = fi[3:0]; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic wait_done(input string n, input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    check({n, "_done_seen"}, done, 1'b1);
    @(negedge clk);
  endtask

  // Monitor
  initial begin
    logic done_prev;
    exp_t e;
    done_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (done && !done_prev) begin
        if (sb_q.size() == 0) begin
          n_checks++; n_err++;
          $display("FAIL unexpected_done: got done=1 expected no run result");
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_pass"},       pass,       e.pass);
          check({e.name, "_timed_out"},  timed_out,  e.tmo);
          check({e.name, "_fail_count"}, fail_count, e.fc);
          check({e.name, "_fail_idx"},   fail_idx,   e.fi);
          check({e.name, "_busy"},       busy,       1'b0);
          if (e.lat >= 0) check({e.name, "_latency"}, 64'(cyc - start_cyc), 64'(e.lat));
        end
      end
      done_prev = done;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of stimulus expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_pass", pass, 1'b0);
    check("rst_timed_out", timed_out, 1'b0);
    check("rst_fail_count", fail_count, 5'd0);
    check("rst_fail_idx", fail_idx, 4'd0);
    rst = 1'b0;

    // 1: all checks pass after the WAIT releases
    prog(0, ent(OP_WAIT, 20, 1));
    prog(1, ent(OP_CHECK, 1, 300));
    prog(2, ent(OP_CHECK, 3, 12));
    prog(3, ent(OP_END, 0, 0));
    expect_run("t1", 1'b1, 1'b0, 0, 0, 9);
    pulse_start();
    wb(1, 300); wb(3, 12); wb(20, 1);
    wait_done("t1", 60);

    // 2: x1 wrong -> one mismatch at entry 1
    wb(20, 0); wb(1, 299);
    expect_run("t2", 1'b0, 1'b0, 1, 1, 5);
    pulse_start();
    wb(20, 1);
    wait_done("t2", 60);

    // 2b: x1 and x3 wrong -> entry 2 still runs, first index kept
    wb(20, 0); wb(3, 13);
    expect_run("t2b", 1'b0, 1'b0, 2, 1, 5);
    pulse_start();
    wb(20, 1);
    wait_done("t2b", 60);

    // 3: WAIT never satisfied -> timeout exactly 50 cycles after start
    prog(0, ent(OP_WAIT, 20, 2));
    prog(1, ent(OP_END, 0, 0));
    expect_run("t3", 1'b0, 1'b1, 0, 0, 50);
    pulse_start();
    wait_done("t3", 80);

    // 4: WAIT satisfied by a write in the evaluation cycle (bypass)
    prog(0, ent(OP_WAIT, 5, 32'hFFFF_FF5C));
    prog(1, ent(OP_CHECK, 5, 32'hFFFF_FF5C));
    prog(2, ent(OP_END, 0, 0));
    expect_run("t4", 1'b1, 1'b0, 0, 0, 3);
    pulse_start();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'hFFFF_FF5C;
    @(negedge clk);
    wb_we = 1'b0;
    wait_done("t4", 60);

    // 5: x0 stays 0; start and prog_we while busy are ignored
    wb(0, 7);
    prog(0, ent(OP_CHECK, 0, 0));
    prog(1, ent(OP_WAIT, 9, 32'h55));
    prog(2, ent(OP_END, 0, 0));
    expect_run("t5", 1'b1, 1'b0, 0, 0, 4);
    pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("t5_busy_after_restart", busy, 1'b1);
    prog_we = 1'b1; prog_addr = 4'd1; prog_data = ent(OP_WAIT, 9, 32'h66);
    @(negedge clk);
    prog_we = 1'b0;
    wb_we = 1'b1; wb_addr = 5'd9; wb_data = 32'h55;
    @(negedge clk);
    wb_we = 1'b0;
    wait_done("t5", 60);

    // 6: last entry executes without END -> done, mismatch on entry 15 counts
    for (int i = 0; i < 15; i++) prog(i, ent(OP_CHECK, 0, 0));
    prog(15, ent(OP_CHECK, 20, 5));
    expect_run("t6_wrap_fail", 1'b0, 1'b0, 1, 15, 16);
    pulse_start();
    wait_done("t6_wrap_fail", 60);
    prog(15, ent(OP_CHECK, 20, 1));
    expect_run("t6_wrap_pass", 1'b1, 1'b0, 0, 0, 16);
    pulse_start();
    wait_done("t6_wrap_pass", 60);

    // 7: reset mid-run, then rerun from entry 0 with a cleared shadow
    wb(7, 9);
    prog(0, ent(OP_CHECK, 20, 0));
    prog(1, ent(OP_WAIT, 7, 0));
    prog(2, ent(OP_END, 0, 0));
    pulse_start();
    repeat (3) @(negedge clk);
    check("t7_pre_rst_busy", busy, 1'b1);
    check("t7_pre_rst_fail_count", fail_count, 5'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t7_rst_busy", busy, 1'b0);
    check("t7_rst_done", done, 1'b0);
    check("t7_rst_fail_count", fail_count, 5'd0);
    check("t7_rst_timed_out", timed_out, 1'b0);
    expect_run("t7_rerun", 1'b1, 1'b0, 0, 0, 3);
    pulse_start();
    wait_done("t7_rerun", 60);

    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
